// File: rtl/mips_mem_pkg.sv
// Types and widths shared by the data-memory responder and its storage array.
package mips_mem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory: synchronous write, combinational read, never cleared.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, inserts wait states,
// then returns a one-cycle response with alignment/range error flag.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              writeen,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic              req_ready,
  output logic [DATA_W-1:0] data,
  output logic              resp_valid,
  output logic              stall,
  output logic              err
);
  localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * DEPTH);
  localparam logic [3:0]        CNT_INIT   = 4'(WAIT_CYCLES);

  dmem_state_t       r_state, w_state_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_data;
  logic              r_resp_valid;
  logic              r_err;

  logic              w_accept;
  logic [ADDR_W-1:0] w_addr_cur;
  logic              w_we_cur;
  logic              w_err;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  assign w_accept   = req_valid && (r_state == IDLE);
  // With no wait states RESP is entered on the acceptance edge, before the latch is visible.
  assign w_addr_cur = (r_state == IDLE) ? address : r_addr;
  assign w_we_cur   = (r_state == IDLE) ? writeen : r_we;
  assign w_idx      = w_addr_cur[IDX_W+1:2];
  assign w_err      = (w_addr_cur[1:0] != 2'b00) || (w_addr_cur >= ADDR_LIMIT);
  assign w_mem_we   = (r_state == RESP) && r_we && !w_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = RESP;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= address;
      r_wdata <= writedata;
      r_we    <= writeen;
    end
  end

  // Response registers change only on the edge that enters RESP, so data/err hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= (w_state_next == RESP);
      if (w_state_next == RESP) begin
        r_err  <= w_err;
        r_data <= (w_err || w_we_cur) ? '0 : w_rdata;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign stall      = ((r_state == IDLE) && req_valid) || (r_state == WAIT);
  assign resp_valid = r_resp_valid;
  assign data       = r_data;
  assign err        = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states), directed literal
// checks plus a randomized run scored every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a   [2];
  logic        rv_in   [2];
  logic        we_in   [2];
  logic [31:0] addr_in [2];
  logic [31:0] wd_in   [2];
  logic        ready_o [2];
  logic        resp_o  [2];
  logic        stall_o [2];
  logic        err_o   [2];
  logic [31:0] data_o  [2];

  int n_cmp_d = 0;
  int n_bad_d = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 2 : 0;

    dmem_responder #(
      .DEPTH       (256),
      .WAIT_CYCLES (W)
    ) u_dut (
      .clk        (clk),
      .reset      (rst_a[gi]),
      .req_valid  (rv_in[gi]),
      .writeen    (we_in[gi]),
      .address    (addr_in[gi]),
      .writedata  (wd_in[gi]),
      .req_ready  (ready_o[gi]),
      .data       (data_o[gi]),
      .resp_valid (resp_o[gi]),
      .stall      (stall_o[gi]),
      .err        (err_o[gi])
    );

    // Transaction model: one outstanding request, response due W+1 cycles after acceptance.
    int unsigned cyc       = 0;
    int unsigned resp_cyc  = 0;
    int          n_cmp     = 0;
    int          n_bad     = 0;
    bit          busy      = 1'b0;
    bit          p_we, p_err, p_known;
    logic [7:0]  p_idx;
    logic [31:0] p_wd, p_data;
    logic [31:0] last_data = '0;
    bit          last_err  = 1'b0;
    bit          last_known = 1'b1;
    logic [31:0] mm [256];
    bit          kn [256];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL model inst%0d %s cyc %0d: got %h want %h", gi, nm, cyc, got, exp);
      end
    endtask

    always @(negedge clk) begin : p_check
      bit          e_rv, e_rdy, e_stall;
      logic [31:0] a;
      cyc++;
      if (!rst_a[gi]) begin
        busy       = 1'b0;
        last_data  = '0;
        last_err   = 1'b0;
        last_known = 1'b1;
        e_rv       = 1'b0;
        e_rdy      = 1'b1;
        e_stall    = rv_in[gi];
      end else begin
        e_rdy   = !busy;
        e_stall = (!busy && rv_in[gi]) || (busy && cyc < resp_cyc);
        e_rv    = busy && (cyc == resp_cyc);
        if (e_rv) begin
          last_data  = p_data;
          last_err   = p_err;
          last_known = p_known;
        end
      end
      chk("resp_valid", 32'(resp_o[gi]), 32'(e_rv));
      chk("req_ready", 32'(ready_o[gi]), 32'(e_rdy));
      chk("stall", 32'(stall_o[gi]), 32'(e_stall));
      chk("err", 32'(err_o[gi]), 32'(last_err));
      if (last_known) chk("data", data_o[gi], last_data);
      if (rst_a[gi]) begin
        if (e_rv) begin
          if (p_we && !p_err) begin
            mm[p_idx] = p_wd;
            kn[p_idx] = 1'b1;
          end
          busy = 1'b0;
        end
        if (e_rdy && rv_in[gi]) begin
          a        = addr_in[gi];
          p_err    = (a % 4 != 0) || (a >= 32'd1024);
          p_idx    = 8'((a / 4) % 256);
          p_we     = we_in[gi];
          p_wd     = wd_in[gi];
          p_data   = (p_err || p_we) ? 32'h0 : mm[p_idx];
          p_known  = p_err || p_we || kn[p_idx];
          busy     = 1'b1;
          resp_cyc = cyc + W + 1;
        end
      end
    end
  end

  task automatic lchk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp_d++;
    if (got !== exp) begin
      n_bad_d++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Issue one request on instance k and wait (bounded) for its response.
  task automatic req(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rdata, output logic rerr);
    int n;
    we_in[k] = we; addr_in[k] = a; wd_in[k] = d; rv_in[k] = 1'b1;
    n = 0;
    while (!ready_o[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    rv_in[k] = 1'b0; addr_in[k] = $urandom; wd_in[k] = $urandom;
    we_in[k] = 1'($urandom_range(0, 1));
    lat = -1; rdata = 'x; rerr = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_o[k] === 1'b1) begin
        lat = i; rdata = data_o[k]; rerr = err_o[k];
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_resp(input string nm, input int k, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err);
    int          lat;
    logic [31:0] rd;
    logic        re;
    req(k, we, a, d, lat, rd, re);
    lchk({nm, "_lat"}, lat, (k == 0) ? 32'd3 : 32'd1);
    lchk({nm, "_data"}, rd, exp_data);
    lchk({nm, "_err"}, 32'(re), 32'(exp_err));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_a[k] = 1'b1; rv_in[k] = 1'b0; we_in[k] = 1'b0; addr_in[k] = '0; wd_in[k] = '0;
    end
    #2;
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rv_in[0] = 1'b1;
    @(negedge clk);
    lchk("rst_resp_valid", 32'(resp_o[0]), 32'd0);
    lchk("rst_data", data_o[0], 32'd0);
    lchk("rst_err", 32'(err_o[0]), 32'd0);
    lchk("rst_ready", 32'(ready_o[0]), 32'd1);
    lchk("rst_stall", 32'(stall_o[0]), 32'd1);
    @(posedge clk); #1;
    rv_in[0] = 1'b0;
    rst_a[0] = 1'b1; rst_a[1] = 1'b1;
    @(posedge clk); #1;

    // Store DEADBEEF @0x10, cycle-by-cycle handshake with inputs scrambled during WAIT.
    we_in[0] = 1'b1; addr_in[0] = 32'h10; wd_in[0] = 32'hDEADBEEF; rv_in[0] = 1'b1;
    @(negedge clk);
    lchk("st_c0_stall", 32'(stall_o[0]), 32'd1);
    lchk("st_c0_ready", 32'(ready_o[0]), 32'd1);
    @(posedge clk); #1;
    rv_in[0] = 1'b0; addr_in[0] = 32'h44; wd_in[0] = 32'h0BADF00D; we_in[0] = 1'b0;
    @(negedge clk);
    lchk("st_c1_stall", 32'(stall_o[0]), 32'd1);
    lchk("st_c1_ready", 32'(ready_o[0]), 32'd0);
    lchk("st_c1_resp", 32'(resp_o[0]), 32'd0);
    @(posedge clk); #1;
    addr_in[0] = 32'h13; we_in[0] = 1'b1;
    @(negedge clk);
    lchk("st_c2_stall", 32'(stall_o[0]), 32'd1);
    @(negedge clk);
    lchk("st_c3_resp", 32'(resp_o[0]), 32'd1);
    lchk("st_c3_err", 32'(err_o[0]), 32'd0);
    lchk("st_c3_stall", 32'(stall_o[0]), 32'd0);
    lchk("st_c3_data", data_o[0], 32'd0);
    @(negedge clk);
    lchk("st_c4_ready", 32'(ready_o[0]), 32'd1);
    lchk("st_c4_resp", 32'(resp_o[0]), 32'd0);
    @(posedge clk); #1;

    expect_resp("ld10", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    expect_resp("ld12", 0, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    expect_resp("ld400", 0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    expect_resp("st12", 0, 1'b1, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
    expect_resp("st0", 0, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
    expect_resp("st400", 0, 1'b1, 32'h400, 32'h5A5A5A5A, 32'h0, 1'b1);
    expect_resp("ld0", 0, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
    expect_resp("ld10b", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset during WAIT of a store must drop it entirely.
    expect_resp("st20", 0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    we_in[0] = 1'b1; addr_in[0] = 32'h20; wd_in[0] = 32'h12345678; rv_in[0] = 1'b1;
    @(posedge clk); #1;
    rv_in[0] = 1'b0;
    rst_a[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      lchk("rstw_resp", 32'(resp_o[0]), 32'd0);
    end
    @(posedge clk); #1;
    rst_a[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      lchk("rstw_after_resp", 32'(resp_o[0]), 32'd0);
    end
    @(posedge clk); #1;
    expect_resp("ld20", 0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // Zero wait states: back-to-back loads accepted two cycles apart.
    expect_resp("w0_st0", 1, 1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0);
    expect_resp("w0_st4", 1, 1'b1, 32'h4, 32'h22222222, 32'h0, 1'b0);
    we_in[1] = 1'b0; addr_in[1] = 32'h0; rv_in[1] = 1'b1;
    @(negedge clk);
    lchk("w0_a_ready", 32'(ready_o[1]), 32'd1);
    @(posedge clk); #1;
    addr_in[1] = 32'h4;
    @(negedge clk);
    lchk("w0_a_resp", 32'(resp_o[1]), 32'd1);
    lchk("w0_a_data", data_o[1], 32'h11111111);
    lchk("w0_a_ready_resp", 32'(ready_o[1]), 32'd0);
    lchk("w0_a_stall", 32'(stall_o[1]), 32'd0);
    @(negedge clk);
    lchk("w0_b_ready", 32'(ready_o[1]), 32'd1);
    lchk("w0_b_stall", 32'(stall_o[1]), 32'd1);
    lchk("w0_b_resp_low", 32'(resp_o[1]), 32'd0);
    @(posedge clk); #1;
    rv_in[1] = 1'b0;
    @(negedge clk);
    lchk("w0_b_resp", 32'(resp_o[1]), 32'd1);
    lchk("w0_b_data", data_o[1], 32'h22222222);
    @(posedge clk); #1;

    // Randomized traffic on both instances, including rare reset pulses.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        rv_in[k] = ($urandom_range(0, 99) < 60);
        we_in[k] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0:       addr_in[k] = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
          1:       addr_in[k] = 32'h400 + 32'($urandom_range(0, 255)) * 4;
          2:       addr_in[k] = $urandom | 32'h400;
          default: addr_in[k] = 32'($urandom_range(0, 63)) * 4;
        endcase
        wd_in[k]  = $urandom;
        rst_a[k]  = ($urandom_range(0, 99) != 0);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      rst_a[k] = 1'b1; rv_in[k] = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp_d + g_dut[0].n_cmp + g_dut[1].n_cmp,
             n_bad_d + g_dut[0].n_bad + g_dut[1].n_bad);
    $finish;
  end
endmodule
